rsa_out_collector: RTL and testbench

//  Downstream of the RSA systolic array. Captures the X*Y result stream (out_val/out_data) into a register buffer.
//  RSA has no back-pressure, so capture never stalls.

---
 rtl/rsa_pkg.sv | 38 +++
 rtl/rsa_sat.sv | 14 +
 rtl/rsa_out_collector.sv | 196 +++++++++++++++++++
 tb/tb_rsa_out_collector.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/rsa_pkg.sv
// Shared types and helpers for the RSA result collector: state encoding,
// index-width helper and the signed saturation function.
package rsa_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_DRAIN = 2'd2
  } coll_state_e;

  localparam int SAT_W     = 64;
  localparam int IDX_W_MIN = 1;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : IDX_W_MIN;
  endfunction

  function automatic logic signed [SAT_W-1:0] sat_signed(
    input logic signed [SAT_W-1:0] value,
    input int                      in_w,
    input int                      out_w
  );
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    min_v = -max_v - 64'sd1;
    if (out_w >= in_w) begin
      sat_signed = value;
    end else if (value > max_v) begin
      sat_signed = max_v;
    end else if (value < min_v) begin
      sat_signed = min_v;
    end else begin
      sat_signed = value;
    end
  endfunction

endpackage

// File: rtl/rsa_sat.sv
// Combinational signed saturator from IN_W to OUT_W bits (pass-through when OUT_W >= IN_W).
module rsa_sat
  import rsa_pkg::*;
#(
  parameter int IN_W  = 9,
  parameter int OUT_W = 8
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout
);

  assign dout = OUT_W'(sat_signed(SAT_W'($signed(din)), IN_W, OUT_W));

endmodule

// File: rtl/rsa_out_collector.sv
// Buffers one X*Y RSA result frame and replays it over valid/ready with (row,col) tags.
// Optional K-tile accumulation is enabled by defining RSA_COLLECT_ACC_EN.
module rsa_out_collector
  import rsa_pkg::*;
#(
  parameter int X       = 3,
  parameter int Y       = 3,
  parameter int OUT_LEN = 8,
  parameter int RES_LEN = 8
) (
  input  logic                 clk,
  input  logic                 sys_rst,
  input  logic                 in_val,
  input  logic [OUT_LEN-1:0]   in_data,
`ifdef RSA_COLLECT_ACC_EN
  input  logic                 acc_last,
`endif
  output logic                 res_val,
  input  logic                 res_rdy,
  output logic [RES_LEN-1:0]   res_data,
  output logic [idx_w(X)-1:0]  res_row,
  output logic [idx_w(Y)-1:0]  res_col,
  output logic                 frame_done,
  output logic                 ovf_err,
  output logic                 busy
);

  localparam int N  = X * Y;
  localparam int RW = idx_w(X);
  localparam int CW = idx_w(Y);
  localparam int AW = idx_w(N);
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(X - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(Y - 1);

  coll_state_e        state_r;
  logic [AW-1:0]      wr_cnt_r;
  logic [RW-1:0]      row_r;
  logic [CW-1:0]      col_r;
  logic [OUT_LEN-1:0] buf_mem_r [N];
  logic               res_val_r;
  logic [RES_LEN-1:0] res_data_r;
  logic               frame_done_r;
  logic               ovf_err_r;

  logic [AW-1:0]      wr_idx_s;
  logic               wr_en_s;
  logic               frame_end_s;
  logic               go_drain_s;
  logic [OUT_LEN-1:0] wr_val_s;
  logic               xfer_s;
  logic               last_xfer_s;
  logic [RW-1:0]      nxt_row_s;
  logic [CW-1:0]      nxt_col_s;
  logic [AW-1:0]      rd_idx_s;
  logic [OUT_LEN-1:0] rd_src_s;
  logic [RES_LEN-1:0] res_sat_s;

  assign wr_idx_s    = (state_r == ST_IDLE) ? '0 : wr_cnt_r;
  assign wr_en_s     = in_val && (state_r != ST_DRAIN);
  assign frame_end_s = wr_en_s && (wr_idx_s == LAST_IDX);
  assign xfer_s      = res_val_r && res_rdy;
  assign last_xfer_s = xfer_s && (row_r == LAST_ROW) && (col_r == LAST_COL);

`ifdef RSA_COLLECT_ACC_EN
  logic               acc_first_r;
  logic               acc_last_r;
  logic               acc_last_eff_s;
  logic [OUT_LEN:0]   acc_sum_s;
  logic [OUT_LEN-1:0] acc_sat_s;

  // The acc_last of a one-beat frame has not been latched yet, so use the live pin.
  assign acc_last_eff_s = (state_r == ST_IDLE) ? acc_last : acc_last_r;
  assign go_drain_s     = frame_end_s && acc_last_eff_s;
  assign acc_sum_s      = {in_data[OUT_LEN-1], in_data}
                        + {buf_mem_r[wr_idx_s][OUT_LEN-1], buf_mem_r[wr_idx_s]};
  assign wr_val_s       = acc_first_r ? in_data : acc_sat_s;

  rsa_sat #(.IN_W(OUT_LEN + 1), .OUT_W(OUT_LEN)) u_acc_sat (
    .din  (acc_sum_s),
    .dout (acc_sat_s)
  );

  // Tracks whether the next frame overwrites or accumulates, and its acc_last.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      acc_first_r <= 1'b1;
      acc_last_r  <= 1'b0;
    end else begin
      if (state_r == ST_IDLE && in_val) acc_last_r <= acc_last;
      if (last_xfer_s) begin
        acc_first_r <= 1'b1;
      end else if (frame_end_s && !go_drain_s) begin
        acc_first_r <= 1'b0;
      end
    end
  end
`else
  assign go_drain_s = frame_end_s;
  assign wr_val_s   = in_data;
`endif

  // Read pointer for the result presented after the coming edge.
  always_comb begin
    nxt_row_s = row_r;
    nxt_col_s = col_r;
    if (state_r != ST_DRAIN) begin
      nxt_row_s = '0;
      nxt_col_s = '0;
    end else if (xfer_s) begin
      if (col_r == LAST_COL) begin
        nxt_col_s = '0;
        nxt_row_s = row_r + RW'(1);
      end else begin
        nxt_col_s = col_r + CW'(1);
        nxt_row_s = row_r;
      end
    end else begin
      nxt_row_s = row_r;
      nxt_col_s = col_r;
    end
  end

  assign rd_idx_s = AW'(int'(nxt_row_s) * Y + int'(nxt_col_s));
  // Bypass covers a frame whose last write lands on the first read slot.
  assign rd_src_s = (wr_en_s && (wr_idx_s == rd_idx_s)) ? wr_val_s : buf_mem_r[rd_idx_s];

  rsa_sat #(.IN_W(OUT_LEN), .OUT_W(RES_LEN)) u_out_sat (
    .din  (rd_src_s),
    .dout (res_sat_s)
  );

  // Collector FSM, buffer writes and registered result port.
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_r      <= ST_IDLE;
      wr_cnt_r     <= '0;
      row_r        <= '0;
      col_r        <= '0;
      res_val_r    <= 1'b0;
      res_data_r   <= '0;
      frame_done_r <= 1'b0;
      ovf_err_r    <= 1'b0;
      for (int i = 0; i < N; i++) buf_mem_r[i] <= '0;
    end else begin
      frame_done_r <= 1'b0;
      if (wr_en_s) buf_mem_r[wr_idx_s] <= wr_val_s;
      case (state_r)
        ST_IDLE, ST_FILL: begin
          if (in_val) begin
            if (frame_end_s) begin
              wr_cnt_r <= '0;
              if (go_drain_s) begin
                state_r    <= ST_DRAIN;
                res_val_r  <= 1'b1;
                res_data_r <= res_sat_s;
              end else begin
                state_r <= ST_IDLE;
              end
            end else begin
              wr_cnt_r <= wr_idx_s + AW'(1);
              state_r  <= ST_FILL;
            end
          end
        end
        ST_DRAIN: begin
          if (in_val) ovf_err_r <= 1'b1;
          if (last_xfer_s) begin
            state_r      <= ST_IDLE;
            res_val_r    <= 1'b0;
            row_r        <= '0;
            col_r        <= '0;
            frame_done_r <= 1'b1;
          end else if (xfer_s) begin
            row_r      <= nxt_row_s;
            col_r      <= nxt_col_s;
            res_data_r <= res_sat_s;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          res_val_r <= 1'b0;
        end
      endcase
    end
  end

  assign res_val    = res_val_r;
  assign res_data   = res_data_r;
  assign res_row    = row_r;
  assign res_col    = col_r;
  assign frame_done = frame_done_r;
  assign ovf_err    = ovf_err_r;
  assign busy       = (state_r != ST_IDLE);

endmodule

// File: tb/tb_rsa_out_collector.sv
// Directed self-checking bench for rsa_out_collector (3x3, 8-bit) plus a 2x2 instance
// saturating to 4 bits; the accumulation scenario runs when RSA_COLLECT_ACC_EN is defined.
module tb_rsa_out_collector;

  logic       clk = 1'b0;
  logic       sys_rst;
  logic       in_val, res_rdy;
  logic [7:0] in_data;
  logic       res_val, frame_done, ovf_err, busy;
  logic [7:0] res_data;
  logic [1:0] res_row, res_col;

  logic       s_in_val, s_res_rdy;
  logic [7:0] s_in_data;
  logic       s_res_val, s_frame_done, s_ovf_err, s_busy;
  logic [3:0] s_res_data;
  logic [0:0] s_res_row, s_res_col;
`ifdef RSA_COLLECT_ACC_EN
  logic       acc_last;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  rsa_out_collector #(.X(3), .Y(3), .OUT_LEN(8), .RES_LEN(8)) dut (
    .clk(clk), .sys_rst(sys_rst), .in_val(in_val), .in_data(in_data),
`ifdef RSA_COLLECT_ACC_EN
    .acc_last(acc_last),
`endif
    .res_val(res_val), .res_rdy(res_rdy), .res_data(res_data), .res_row(res_row),
    .res_col(res_col), .frame_done(frame_done), .ovf_err(ovf_err), .busy(busy)
  );

  rsa_out_collector #(.X(2), .Y(2), .OUT_LEN(8), .RES_LEN(4)) dut_sat (
    .clk(clk), .sys_rst(sys_rst), .in_val(s_in_val), .in_data(s_in_data),
`ifdef RSA_COLLECT_ACC_EN
    .acc_last(acc_last),
`endif
    .res_val(s_res_val), .res_rdy(s_res_rdy), .res_data(s_res_data), .res_row(s_res_row),
    .res_col(s_res_col), .frame_done(s_frame_done), .ovf_err(s_ovf_err), .busy(s_busy)
  );

  // Drives nine contiguous beats base, base+step, ...; returns at the negedge after the last beat.
  task automatic send_frame(input int base, input int step);
    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      in_val  = 1'b1;
      in_data = 8'(base + k * step);
    end
    @(negedge clk);
    in_val = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst = 1'b1; in_val = 1'b0; in_data = 8'h00; res_rdy = 1'b0;
    s_in_val = 1'b0; s_in_data = 8'h00; s_res_rdy = 1'b0;
    repeat (3) @(negedge clk);
    sys_rst = 1'b0;
    @(negedge clk);
    checks++; if (res_val !== 1'b0) begin errors++; $display("FAIL reset_res_val got=%b exp=0", res_val); end
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done got=%b exp=0", frame_done); end
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", ovf_err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({res_data, res_row, res_col} !== 12'h000) begin errors++; $display("FAIL reset_outputs got=%h exp=000", {res_data, res_row, res_col}); end
  endtask

  task automatic test_load_drain();
    res_rdy = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      if (k == 9) begin
        checks++; if (res_val !== 1'b0) begin errors++; $display("FAIL ld_early_val got=%b exp=0", res_val); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL ld_busy_fill got=%b exp=1", busy); end
      end
      in_val = 1'b1; in_data = 8'(k);
    end
    @(negedge clk);
    in_val = 1'b0;
    for (int i = 0; i < 9; i++) begin
      checks++; if (res_val !== 1'b1) begin errors++; $display("FAIL ld_val[%0d] got=%b exp=1", i, res_val); end
      checks++; if (res_data !== 8'(i + 1)) begin errors++; $display("FAIL ld_data[%0d] got=%0d exp=%0d", i, res_data, i + 1); end
      checks++; if ({res_row, res_col} !== {2'(i / 3), 2'(i % 3)}) begin errors++; $display("FAIL ld_rc[%0d] got=%0d,%0d exp=%0d,%0d", i, res_row, res_col, i / 3, i % 3); end
      checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL ld_fd_early[%0d] got=%b exp=0", i, frame_done); end
      @(negedge clk);
    end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL ld_frame_done got=%b exp=1", frame_done); end
    checks++; if (res_val !== 1'b0) begin errors++; $display("FAIL ld_val_end got=%b exp=0", res_val); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ld_busy_end got=%b exp=0", busy); end
    @(negedge clk);
    checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL ld_fd_pulse got=%b exp=0", frame_done); end
  endtask

  task automatic test_saturation();
    logic [7:0] vin  [4];
    logic [3:0] vexp [4];
    vin[0] = 8'h7F; vin[1] = 8'h80; vin[2] = 8'h05; vin[3] = 8'hFB;
    vexp[0] = 4'h7; vexp[1] = 4'h8; vexp[2] = 4'h5; vexp[3] = 4'hB;
    s_res_rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      s_in_val = 1'b1; s_in_data = vin[k];
    end
    @(negedge clk);
    s_in_val = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (s_res_val !== 1'b1) begin errors++; $display("FAIL sat_val[%0d] got=%b exp=1", i, s_res_val); end
      checks++; if (s_res_data !== vexp[i]) begin errors++; $display("FAIL sat_data[%0d] got=%h exp=%h", i, s_res_data, vexp[i]); end
      @(negedge clk);
    end
    checks++; if (s_frame_done !== 1'b1) begin errors++; $display("FAIL sat_frame_done got=%b exp=1", s_frame_done); end
  endtask

  task automatic test_backpressure();
    logic       rdy_v = 1'b0;
    logic       stalled = 1'b0;
    logic [7:0] held = 8'h00;
    int         n = 0;
    res_rdy = 1'b0;
    send_frame(21, 1);
    for (int c = 0; c < 60 && n < 9; c++) begin
      if (res_val) begin
        if (stalled) begin
          checks++; if (res_data !== held) begin errors++; $display("FAIL bp_stable[%0d] got=%0d exp=%0d", c, res_data, held); end
        end
        res_rdy = rdy_v;
        if (rdy_v) begin
          checks++; if (res_data !== 8'(21 + n)) begin errors++; $display("FAIL bp_data[%0d] got=%0d exp=%0d", n, res_data, 21 + n); end
          n++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = res_data;
        end
      end else begin
        res_rdy = rdy_v;
      end
      rdy_v = ~rdy_v;
      @(negedge clk);
    end
    checks++; if (n !== 9) begin errors++; $display("FAIL bp_count got=%0d exp=9", n); end
    checks++; if (res_val !== 1'b0) begin errors++; $display("FAIL bp_extra_val got=%b exp=0", res_val); end
    checks++; if (frame_done !== 1'b1) begin errors++; $display("FAIL bp_frame_done got=%b exp=1", frame_done); end
    res_rdy = 1'b0;
  endtask

  task automatic test_overflow();
    res_rdy = 1'b0;
    send_frame(1, 1);
    in_val = 1'b1; in_data = 8'hAA;
    @(negedge clk);
    in_val = 1'b0;
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_set got=%b exp=1", ovf_err); end
    res_rdy = 1'b1;
    for (int i = 0; i < 9; i++) begin
      checks++; if (res_data !== 8'(i + 1)) begin errors++; $display("FAIL ovf_data[%0d] got=%0d exp=%0d", i, res_data, i + 1); end
      @(negedge clk);
    end
    repeat (2) @(negedge clk);
    checks++; if (ovf_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", ovf_err); end
  endtask

  task automatic test_reset_mid_frame();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      in_val = 1'b1; in_data = 8'(11 + k);
    end
    @(negedge clk);
    in_val = 1'b0; sys_rst = 1'b1;
    @(negedge clk);
    sys_rst = 1'b0;
    @(negedge clk);
    checks++; if (ovf_err !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b exp=0", ovf_err); end
    checks++; if ({busy, res_val} !== 2'b00) begin errors++; $display("FAIL rst_idle got=%b exp=00", {busy, res_val}); end
    res_rdy = 1'b1;
    send_frame(11, 1);
    for (int i = 0; i < 9; i++) begin
      checks++; if ({res_val, res_data} !== {1'b1, 8'(11 + i)}) begin errors++; $display("FAIL rst_data[%0d] got=%b/%0d exp=1/%0d", i, res_val, res_data, 11 + i); end
      @(negedge clk);
    end
    checks++; if (res_val !== 1'b0) begin errors++; $display("FAIL rst_extra got=%b exp=0", res_val); end
  endtask

`ifdef RSA_COLLECT_ACC_EN
  task automatic test_accumulate();
    res_rdy = 1'b1;
    acc_last = 1'b0;
    send_frame(3, 0);
    acc_last = 1'b1;
    repeat (3) begin
      checks++; if ({busy, res_val} !== 2'b00) begin errors++; $display("FAIL acc_no_drain got=%b exp=00", {busy, res_val}); end
      @(negedge clk);
    end
    send_frame(4, 0);
    for (int i = 0; i < 9; i++) begin
      checks++; if ({res_val, res_data} !== {1'b1, 8'd7}) begin errors++; $display("FAIL acc_data[%0d] got=%b/%0d exp=1/7", i, res_val, res_data); end
      @(negedge clk);
    end
  endtask
`endif

  initial begin
`ifdef RSA_COLLECT_ACC_EN
    acc_last = 1'b1;
`endif
    test_reset();
    test_load_drain();
    test_saturation();
    test_backpressure();
    test_overflow();
    test_reset_mid_frame();
`ifdef RSA_COLLECT_ACC_EN
    test_accumulate();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
